// File: rtl/pipe_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipe_adder: carry-pipelined add/subtract, one WIDTH/STAGES-bit slice   |
// | resolved per stage, valid/ready flow control with a global stall.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int SW = WIDTH / STAGES;

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic [WIDTH-1:0] w_s     [STAGES];
    logic             w_cin   [STAGES];
    logic             w_v     [STAGES];
    logic [SW:0]      w_slice [STAGES];
    logic             w_ovf;
    logic             w_advance;

    assign w_advance = out_ready_i || !r_v[STAGES-1];

    // Each stage sees the previous stage's registers (operands at stage 0),
    // adds its own slice and overwrites only that slice of the partial sum.
    always_comb begin
        w_a[0]   = a_i;
        w_b[0]   = sub_i ? ~b_i : b_i;
        w_cin[0] = sub_i | carry_i;
        w_s[0]   = '0;
        w_v[0]   = in_valid_i;
        for (int k = 1; k < STAGES; k++) begin
            w_a[k]   = r_a[k-1];
            w_b[k]   = r_b[k-1];
            w_cin[k] = r_c[k-1];
            w_s[k]   = r_s[k-1];
            w_v[k]   = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_a[k][k*SW +: SW]} + {1'b0, w_b[k][k*SW +: SW]}
                       + (SW+1)'(w_cin[k]);
            w_s[k][k*SW +: SW] = w_slice[k][SW-1:0];
        end
        // Carry into the MSB is recovered from the MSB's own sum bit.
        w_ovf = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
              ^ w_slice[STAGES-1][SW-1] ^ w_slice[STAGES-1][SW];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a[k];
                r_b[k] <= w_b[k];
                r_s[k] <= w_s[k];
                r_c[k] <= w_slice[k][SW];
                r_v[k] <= w_v[k];
            end
            r_ovf <= w_ovf;
        end
    end

    assign in_ready_o  = w_advance;
    assign sum_o       = r_s[STAGES-1];
    assign carry_o     = r_c[STAGES-1];
    assign ovf_o       = r_ovf;
    assign out_valid_o = r_v[STAGES-1];

endmodule
`default_nettype wire
